// File: rtl/cardinal_pkg.sv
// Shared definitions for the Cardinal vector datapath: ALU function codes,
// element-width codes, participation (ppp) codes and default datapath sizes.
package cardinal_pkg;

   localparam int DATA_W_DEFAULT   = 64;
   localparam int ADDR_W_DEFAULT   = 5;
   localparam int NUM_REGS_DEFAULT = 32;
   localparam int NUM_BYTES        = 8;

   localparam logic [0:5] NOP    = 6'd0;
   localparam logic [0:5] VAND   = 6'd1;
   localparam logic [0:5] VOR    = 6'd2;
   localparam logic [0:5] VXOR   = 6'd3;
   localparam logic [0:5] VNOT   = 6'd4;
   localparam logic [0:5] VMOV   = 6'd5;
   localparam logic [0:5] VADD   = 6'd6;
   localparam logic [0:5] VSUB   = 6'd7;
   localparam logic [0:5] VMULEU = 6'd8;
   localparam logic [0:5] VMULOU = 6'd9;
   localparam logic [0:5] VSLL   = 6'd10;
   localparam logic [0:5] VSRL   = 6'd11;
   localparam logic [0:5] VSRA   = 6'd12;
   localparam logic [0:5] VRTTH  = 6'd13;
   localparam logic [0:5] VDIV   = 6'd14;
   localparam logic [0:5] VMOD   = 6'd15;
   localparam logic [0:5] VSQEU  = 6'd16;
   localparam logic [0:5] VSQOU  = 6'd17;
   localparam logic [0:5] VSQRT  = 6'd18;

   localparam logic [0:1] bMode = 2'b00;
   localparam logic [0:1] hMode = 2'b01;
   localparam logic [0:1] wMode = 2'b10;
   localparam logic [0:1] dMode = 2'b11;

   localparam logic [0:2] PPP_A = 3'b000;
   localparam logic [0:2] PPP_U = 3'b001;
   localparam logic [0:2] PPP_D = 3'b010;
   localparam logic [0:2] PPP_E = 3'b011;
   localparam logic [0:2] PPP_O = 3'b100;

endpackage

// File: rtl/cardinal_ppp_mask.sv
// Translates a Cardinal participation field into a per-byte enable mask.
// Byte 0 is the most significant byte (bits 0:7). Reserved codes yield no bytes.
module cardinal_ppp_mask
   import cardinal_pkg::*;
(
   input  logic [0:2] ppp,
   output logic [0:7] mask
);

   // Decode the participation code into the set of bytes it covers
   always_comb begin
      mask = 8'b0000_0000;
      case (ppp)
         PPP_A:   mask = 8'b1111_1111;
         PPP_U:   mask = 8'b1111_0000;
         PPP_D:   mask = 8'b0000_1111;
         PPP_E:   mask = 8'b1010_1010;
         PPP_O:   mask = 8'b0101_0101;
         default: mask = 8'b0000_0000;
      endcase
   end

endmodule

// File: rtl/cardinal_regfile_idex.sv
// Cardinal vector register file (32 x 64, big-endian bit order) together with
// the ID/EX pipeline register feeding the EX-stage ALU.
// Optional build macro CARDINAL_RF_BYPASS_EN: when defined, a same-cycle
// writeback is forwarded into the operand reads for its participating bytes.
// When undefined, reads see only the stored (pre-write) contents.
module cardinal_regfile_idex
   import cardinal_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int NUM_REGS = NUM_REGS_DEFAULT,
   parameter int ADDR_W   = ADDR_W_DEFAULT
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              stallEX,
   input  logic              flushEX,
   input  logic              validID,
   input  logic [0:ADDR_W-1] rAaddrID,
   input  logic [0:ADDR_W-1] rBaddrID,
   input  logic [0:ADDR_W-1] rDaddrID,
   input  logic [0:5]        functionCodeID,
   input  logic [0:1]        wwID,
   input  logic [0:2]        pppID,
   input  logic              wbEn,
   input  logic [0:ADDR_W-1] wbAddr,
   input  logic [0:DATA_W-1] wbData,
   input  logic [0:2]        wbPpp,
   output logic [0:DATA_W-1] rAex,
   output logic [0:DATA_W-1] rBex,
   output logic [0:5]        functionCodeEX,
   output logic [0:1]        wwEX,
   output logic [0:ADDR_W-1] rDaddrEX,
   output logic [0:2]        pppEX,
   output logic              validEX
);

   logic [0:DATA_W-1] regs [NUM_REGS];
   logic [0:7]        wbMask;
   logic [0:DATA_W-1] readA;
   logic [0:DATA_W-1] readB;

   // One mask decoder serves both the write port and the bypass merge
   cardinal_ppp_mask u_wbMask (
      .ppp  (wbPpp),
      .mask (wbMask)
   );

   // Writeback port: only participating bytes of the target entry change
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else if (wbEn) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (wbMask[b]) begin
               regs[wbAddr][8*b +: 8] <= wbData[8*b +: 8];
            end
         end
      end
   end

   // Operand reads; with bypass enabled a same-cycle writeback is merged in
   always_comb begin
      readA = regs[rAaddrID];
      readB = regs[rBaddrID];
`ifdef CARDINAL_RF_BYPASS_EN
      if (wbEn && (wbAddr == rAaddrID)) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (wbMask[b]) begin
               readA[8*b +: 8] = wbData[8*b +: 8];
            end
         end
      end
      if (wbEn && (wbAddr == rBaddrID)) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (wbMask[b]) begin
               readB[8*b +: 8] = wbData[8*b +: 8];
            end
         end
      end
`endif
   end

   // ID/EX register: flush beats stall, stall holds, otherwise capture ID
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rAex           <= '0;
         rBex           <= '0;
         functionCodeEX <= NOP;
         wwEX           <= '0;
         rDaddrEX       <= '0;
         pppEX          <= '0;
         validEX        <= 1'b0;
      end else if (flushEX) begin
         rAex           <= '0;
         rBex           <= '0;
         functionCodeEX <= NOP;
         wwEX           <= '0;
         rDaddrEX       <= '0;
         pppEX          <= '0;
         validEX        <= 1'b0;
      end else if (!stallEX) begin
         rAex           <= readA;
         rBex           <= readB;
         functionCodeEX <= functionCodeID;
         wwEX           <= wwID;
         rDaddrEX       <= rDaddrID;
         pppEX          <= pppID;
         validEX        <= validID;
      end
   end

endmodule

// File: tb/tb_cardinal_regfile_idex.sv
// Self-checking bench for cardinal_regfile_idex: directed scenarios followed by
// randomized traffic, all compared against a byte-level behavioural model.
module tb_cardinal_regfile_idex;
   import cardinal_pkg::*;

   logic        clk;
   logic        reset;
   logic        stallEX;
   logic        flushEX;
   logic        validID;
   logic [0:4]  rAaddrID;
   logic [0:4]  rBaddrID;
   logic [0:4]  rDaddrID;
   logic [0:5]  functionCodeID;
   logic [0:1]  wwID;
   logic [0:2]  pppID;
   logic        wbEn;
   logic [0:4]  wbAddr;
   logic [0:63] wbData;
   logic [0:2]  wbPpp;
   logic [0:63] rAex;
   logic [0:63] rBex;
   logic [0:5]  functionCodeEX;
   logic [0:1]  wwEX;
   logic [0:4]  rDaddrEX;
   logic [0:2]  pppEX;
   logic        validEX;

   logic [0:63] mem [32];
   logic [0:63] expRa;
   logic [0:63] expRb;
   logic [0:5]  expFc;
   logic [0:1]  expWw;
   logic [0:4]  expRd;
   logic [0:2]  expPpp;
   logic        expValid;

   int errors = 0;
   int checks = 0;

   cardinal_regfile_idex dut (
      .clk            (clk),
      .reset          (reset),
      .stallEX        (stallEX),
      .flushEX        (flushEX),
      .validID        (validID),
      .rAaddrID       (rAaddrID),
      .rBaddrID       (rBaddrID),
      .rDaddrID       (rDaddrID),
      .functionCodeID (functionCodeID),
      .wwID           (wwID),
      .pppID          (pppID),
      .wbEn           (wbEn),
      .wbAddr         (wbAddr),
      .wbData         (wbData),
      .wbPpp          (wbPpp),
      .rAex           (rAex),
      .rBex           (rBex),
      .functionCodeEX (functionCodeEX),
      .wwEX           (wwEX),
      .rDaddrEX       (rDaddrEX),
      .pppEX          (pppEX),
      .validEX        (validEX)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Does byte b (0 = most significant) take part under participation code p
   function automatic bit participates(logic [0:2] p, int b);
      case (p)
         3'd0:    return 1'b1;
         3'd1:    return b < 4;
         3'd2:    return b >= 4;
         3'd3:    return (b % 2) == 0;
         3'd4:    return (b % 2) == 1;
         default: return 1'b0;
      endcase
   endfunction

   // Value the ID stage should see for register a this cycle
   function automatic logic [0:63] modelRead(logic [0:4] a);
      logic [0:63] v;
      v = mem[a];
`ifdef CARDINAL_RF_BYPASS_EN
      if (wbEn && wbAddr == a) begin
         for (int b = 0; b < 8; b++) begin
            if (participates(wbPpp, b)) v[8*b +: 8] = wbData[8*b +: 8];
         end
      end
`endif
      return v;
   endfunction

   task automatic modelReset();
      for (int r = 0; r < 32; r++) mem[r] = '0;
      expRa = '0; expRb = '0; expFc = '0; expWw = '0;
      expRd = '0; expPpp = '0; expValid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [0:63] observed, input logic [0:63] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".rAex"}, rAex, expRa);
      checkOutput({tag, ".rBex"}, rBex, expRb);
      checkOutput({tag, ".fc"}, 64'(functionCodeEX), 64'(expFc));
      checkOutput({tag, ".ww"}, 64'(wwEX), 64'(expWw));
      checkOutput({tag, ".rd"}, 64'(rDaddrEX), 64'(expRd));
      checkOutput({tag, ".ppp"}, 64'(pppEX), 64'(expPpp));
      checkOutput({tag, ".valid"}, 64'(validEX), 64'(expValid));
   endtask

   // Advance one clock: update the model for this edge, then move past the edge
   task automatic applyStimulus();
      if (flushEX) begin
         expRa = '0; expRb = '0; expFc = '0; expWw = '0;
         expRd = '0; expPpp = '0; expValid = 1'b0;
      end else if (!stallEX) begin
         expRa    = modelRead(rAaddrID);
         expRb    = modelRead(rBaddrID);
         expFc    = functionCodeID;
         expWw    = wwID;
         expRd    = rDaddrID;
         expPpp   = pppID;
         expValid = validID;
      end
      if (wbEn) begin
         for (int b = 0; b < 8; b++) begin
            if (participates(wbPpp, b)) mem[wbAddr][8*b +: 8] = wbData[8*b +: 8];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      stallEX = 1'b0; flushEX = 1'b0; validID = 1'b0;
      rAaddrID = '0; rBaddrID = '0; rDaddrID = '0;
      functionCodeID = NOP; wwID = bMode; pppID = PPP_A;
      wbEn = 1'b0; wbAddr = '0; wbData = '0; wbPpp = PPP_A;
   endtask

   initial begin
      logic [0:63] byp;
      reset = 1'b1;
      idleInputs();
      modelReset();
      #2;
      checkAll("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Every register reads zero after reset
      for (int i = 0; i < 32; i++) begin
         rAaddrID = 5'(i);
         rBaddrID = 5'(31 - i);
         applyStimulus();
         checkOutput("resetRegA", rAex, 64'h0);
         checkOutput("resetRegB", rBex, 64'h0);
      end
      checkOutput("resetValid", 64'(validEX), 64'h0);
      checkOutput("resetFc", 64'(functionCodeEX), 64'h0);

      // Full write then read back
      rAaddrID = 5'd0; rBaddrID = 5'd0;
      wbEn = 1'b1; wbAddr = 5'd5; wbData = 64'h0123456789ABCDEF; wbPpp = PPP_A;
      applyStimulus();
      wbEn = 1'b0; rAaddrID = 5'd5; validID = 1'b1;
      applyStimulus();
      checkOutput("fullWrite", rAex, 64'h0123456789ABCDEF);
      checkAll("fullWrite");

      // Even-byte write
      wbEn = 1'b1; wbData = 64'hFFFFFFFFFFFFFFFF; wbPpp = PPP_E; rAaddrID = 5'd0;
      applyStimulus();
      wbEn = 1'b0; rAaddrID = 5'd5;
      applyStimulus();
      checkOutput("evenWrite", rAex, 64'hFF23FF67FFABFFEF);

      // Upper-half write of zero
      wbEn = 1'b1; wbData = 64'h0; wbPpp = PPP_U; rAaddrID = 5'd0;
      applyStimulus();
      wbEn = 1'b0; rAaddrID = 5'd5;
      applyStimulus();
      checkOutput("upperWrite", rAex, 64'h00000000FFABFFEF);

      // Reserved participation code writes nothing
      wbEn = 1'b1; wbData = 64'h5A5A5A5A5A5A5A5A; wbPpp = 3'b111; rAaddrID = 5'd0;
      applyStimulus();
      wbEn = 1'b0; rAaddrID = 5'd5; rBaddrID = 5'd5;
      applyStimulus();
      checkOutput("reservedPppA", rAex, 64'h00000000FFABFFEF);
      checkOutput("reservedPppB", rBex, 64'h00000000FFABFFEF);

      // Same-cycle writeback and read of r7
      wbEn = 1'b1; wbAddr = 5'd7; wbData = 64'h1111111111111111; wbPpp = PPP_A;
      rAaddrID = 5'd0; rBaddrID = 5'd0;
      applyStimulus();
      wbData = 64'hAAAAAAAAAAAAAAAA; wbPpp = PPP_D; rBaddrID = 5'd7;
      applyStimulus();
`ifdef CARDINAL_RF_BYPASS_EN
      byp = 64'h11111111AAAAAAAA;
`else
      byp = 64'h1111111111111111;
`endif
      checkOutput("bypass", rBex, byp);
      checkAll("bypass");
      wbEn = 1'b0;
      applyStimulus();
      checkOutput("afterBypass", rBex, 64'h11111111AAAAAAAA);

      // Stall holds a VADD/word instruction while ID keeps changing
      functionCodeID = VADD; wwID = wMode; rDaddrID = 5'd3; pppID = PPP_O;
      validID = 1'b1; rAaddrID = 5'd5; rBaddrID = 5'd7;
      applyStimulus();
      checkAll("loadVadd");
      stallEX = 1'b1;
      for (int i = 0; i < 3; i++) begin
         functionCodeID = 6'(VSUB + 6'(i));
         wwID = 2'(i);
         rAaddrID = 5'(i + 10);
         rDaddrID = 5'(i + 20);
         wbEn = 1'b1; wbAddr = 5'd5; wbData = 64'(i * 3 + 1); wbPpp = PPP_A;
         applyStimulus();
         checkOutput("stallFc", 64'(functionCodeEX), 64'(VADD));
         checkOutput("stallWw", 64'(wwEX), 64'(wMode));
         checkAll("stall");
      end
      wbEn = 1'b0;

      // Flush wins over stall
      flushEX = 1'b1;
      applyStimulus();
      checkOutput("flushValid", 64'(validEX), 64'h0);
      checkOutput("flushFc", 64'(functionCodeEX), 64'h0);
      checkAll("flush");
      stallEX = 1'b0; flushEX = 1'b0;

      // Randomized traffic on a small register window to provoke collisions
      for (int n = 0; n < 300; n++) begin
         stallEX        = ($urandom_range(0, 3) == 0);
         flushEX        = ($urandom_range(0, 7) == 0);
         validID        = 1'($urandom);
         rAaddrID       = 5'($urandom_range(0, 7));
         rBaddrID       = 5'($urandom_range(0, 7));
         rDaddrID       = 5'($urandom);
         functionCodeID = 6'($urandom_range(0, 18));
         wwID           = 2'($urandom);
         pppID          = 3'($urandom);
         wbEn           = 1'($urandom);
         wbAddr         = 5'($urandom_range(0, 7));
         wbData         = {32'($urandom), 32'($urandom)};
         wbPpp          = 3'($urandom);
         applyStimulus();
         checkAll("random");
      end

      // Asynchronous reset between edges
      idleInputs();
      validID = 1'b1; functionCodeID = VMOV; rAaddrID = 5'd7;
      applyStimulus();
      #2;
      reset = 1'b1;
      modelReset();
      #1;
      checkAll("asyncReset");
      checkOutput("asyncValid", 64'(validEX), 64'h0);
      reset = 1'b0;
      #1;
      functionCodeID = VSUB; wwID = dMode; validID = 1'b1; rAaddrID = 5'd7;
      applyStimulus();
      checkOutput("postResetFc", 64'(functionCodeEX), 64'(VSUB));
      checkOutput("postResetWw", 64'(wwEX), 64'(dMode));
      checkOutput("postResetRa", rAex, 64'h0);
      checkAll("postReset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
